rtc_bus_sequencer: RTL



---
 rtl/rtc_bus_sequencer.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/rtc_bus_sequencer.sv
// Runs one address/data-multiplexed bus cycle (write or read) to an external RTC.
// Every output is registered from the next-state decode, so strobes never glitch.
module rtc_bus_sequencer #(
  parameter int T_PH = 4  // cycles per bus phase, 1..15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] dir_in,
  input  logic [7:0] data_in,
  input  logic       req,
  input  logic       rw,
  input  logic [7:0] bus_in,
  output logic [7:0] bus_out,
  output logic       bus_oe,
  output logic       cs_n,
  output logic       ad_n,
  output logic       wr_n,
  output logic       rd_n,
  output logic [7:0] rd_data,
  output logic       busy,
  output logic       done
);

  typedef enum logic [2:0] {IDLE, A_STB, A_HOLD, D_STB, D_HOLD, DONE} state_t;

  localparam logic [3:0] PH_LAST = 4'(T_PH - 1);

  state_t     state, state_nxt;
  logic [3:0] cnt, cnt_nxt;
  logic [7:0] addr_q, addr_nxt, data_q, data_nxt;
  logic       rw_q, rw_nxt;
  logic       phase_end;

  logic       cs_d, ad_d, wr_d, rd_d, oe_d, busy_d, done_d;
  logic [7:0] out_d;

  assign phase_end = (cnt == 4'd0);

  always_comb begin
    // NOTE: every signal gets a default before the case so no path can infer a latch.
    state_nxt = state;
    cnt_nxt   = cnt;
    addr_nxt  = addr_q;
    data_nxt  = data_q;
    rw_nxt    = rw_q;
    if (state != IDLE && state != DONE) cnt_nxt = cnt - 4'd1;

    case (state)
      IDLE: if (req) begin
        state_nxt = A_STB;
        cnt_nxt   = PH_LAST;
        addr_nxt  = dir_in;
        data_nxt  = data_in;
        rw_nxt    = rw;
      end
      A_STB:  if (phase_end) begin state_nxt = A_HOLD; cnt_nxt = PH_LAST; end
      A_HOLD: if (phase_end) begin state_nxt = D_STB;  cnt_nxt = PH_LAST; end
      D_STB:  if (phase_end) begin state_nxt = D_HOLD; cnt_nxt = PH_LAST; end
      D_HOLD: if (phase_end) begin state_nxt = DONE;   cnt_nxt = 4'd0;    end
      DONE:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase

    // Decode from the state being entered so the registered pins line up with it.
    cs_d   = 1'b1;
    ad_d   = 1'b1;
    wr_d   = 1'b1;
    rd_d   = 1'b1;
    oe_d   = 1'b0;
    out_d  = 8'h00;
    busy_d = (state_nxt != IDLE);
    done_d = 1'b0;

    case (state_nxt)
      A_STB: begin
        cs_d  = 1'b0;
        ad_d  = 1'b0;
        wr_d  = 1'b0;
        oe_d  = 1'b1;
        out_d = addr_nxt;
      end
      A_HOLD: begin
        oe_d  = 1'b1;
        out_d = addr_nxt;
      end
      D_STB: begin
        cs_d = 1'b0;
        if (rw_nxt) begin
          rd_d = 1'b0;  // pad released: the RTC owns the bus while rd_n is low
        end else begin
          wr_d  = 1'b0;
          oe_d  = 1'b1;
          out_d = data_nxt;
        end
      end
      D_HOLD: if (!rw_nxt) begin
        oe_d  = 1'b1;
        out_d = data_nxt;
      end
      DONE:    done_d = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register updates from pre-edge values.
    if (reset) begin
      state   <= IDLE;
      cnt     <= 4'd0;
      addr_q  <= 8'h00;
      data_q  <= 8'h00;
      rw_q    <= 1'b0;
      cs_n    <= 1'b1;
      ad_n    <= 1'b1;
      wr_n    <= 1'b1;
      rd_n    <= 1'b1;
      bus_oe  <= 1'b0;
      bus_out <= 8'h00;
      busy    <= 1'b0;
      done    <= 1'b0;
      rd_data <= 8'h00;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      addr_q  <= addr_nxt;
      data_q  <= data_nxt;
      rw_q    <= rw_nxt;
      cs_n    <= cs_d;
      ad_n    <= ad_d;
      wr_n    <= wr_d;
      rd_n    <= rd_d;
      bus_oe  <= oe_d;
      bus_out <= out_d;
      busy    <= busy_d;
      done    <= done_d;
      // Sample on the last edge of the read strobe, while rd_n is still low.
      if (state == D_STB && phase_end && rw_q) rd_data <= bus_in;
    end
  end

endmodule
